wb_mem_slave: RTL and testbench

- Wishbone B4 pipelined responder backed by an internal word-addressed memory.
- It is the slave-side counterpart to the bus masters in the design.
- Serves as the standard target for master benches and formal checks, and as a small on-chip RAM.
- Supports a configurable fixed response latency, out-of-range error responses, externally injected stalls, and abort on cycle drop.

---
 rtl/wb_mem_slave.sv | 82 ++++++++
 tb/tb_wb_mem_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - Wishbone B4 pipelined memory responder with fixed latency
module wb_mem_slave #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 30,
  parameter int Depth     = 1024,
  parameter int Latency   = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [DataWidth-1:0]     wb_data_i,
  input  logic [AddrWidth-1:0]     wb_addr_i,
  input  logic [DataWidth/8-1:0]   wb_sel_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic                     stall_inject_i,
  output logic [DataWidth-1:0]     wb_data_o,
  output logic                     wb_ack_o,
  output logic                     wb_stall_o,
  output logic                     wb_err_o
);

  localparam int SelWidth = DataWidth / 8;
  localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
  // Depth widened by one bit so Depth == 2**AddrWidth still compares correctly.
  localparam logic [AddrWidth:0] DepthW = (AddrWidth + 1)'(Depth);

  logic [DataWidth-1:0] mem [Depth];

  logic                 stall_q;
  logic [Latency-1:0]   vld_q;
  logic [Latency-1:0]   err_q;
  logic [DataWidth-1:0] dat_q [Latency];

  logic                 accept;
  logic                 in_range;
  logic [IdxWidth-1:0]  idx;

  assign accept   = wb_cyc_i & wb_stb_i & ~stall_q;
  assign in_range = {1'b0, wb_addr_i} < DepthW;
  assign idx      = wb_addr_i[IdxWidth-1:0];

  // Byte-lane memory write on an accepted in-range write; no reset on storage.
  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i && in_range) begin
      for (int k = 0; k < SelWidth; k++) begin
        if (wb_sel_i[k]) begin
          mem[idx][8*k +: 8] <= wb_data_i[8*k +: 8];
        end
      end
    end
  end

  // Stall register and response pipeline; a dropped cycle flushes all valids.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      stall_q <= 1'b1;
      vld_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < Latency; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      stall_q <= stall_inject_i;
      // Stage 0 captures the new request; read data is the pre-write word.
      vld_q[0] <= wb_cyc_i & accept;
      err_q[0] <= ~in_range;
      dat_q[0] <= (accept && !wb_we_i && in_range) ? mem[idx] : '0;
      for (int i = 1; i < Latency; i++) begin
        vld_q[i] <= wb_cyc_i & vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign wb_stall_o = stall_q;
  assign wb_ack_o   = vld_q[Latency-1] & ~err_q[Latency-1] & wb_cyc_i;
  assign wb_err_o   = vld_q[Latency-1] &  err_q[Latency-1] & wb_cyc_i;
  assign wb_data_o  = wb_ack_o ? dat_q[Latency-1] : '0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb/tb_wb_mem_slave.sv - randomized bench for wb_mem_slave at latency 1 and 3
module tb_wb_mem_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] wb_wdata;
  logic [29:0] wb_addr;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we, stall_inj;

  logic [31:0] data1, data3;
  logic        ack1, ack3, err1, err3, stall1, stall3;

  always #5 clk = ~clk;

  wb_mem_slave #(.DataWidth(32), .AddrWidth(30), .Depth(1024), .Latency(1)) dut_l1 (
    .clk_i(clk), .reset_ni(reset_n), .wb_data_i(wb_wdata), .wb_addr_i(wb_addr),
    .wb_sel_i(wb_sel), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .stall_inject_i(stall_inj), .wb_data_o(data1), .wb_ack_o(ack1),
    .wb_stall_o(stall1), .wb_err_o(err1)
  );

  wb_mem_slave #(.DataWidth(32), .AddrWidth(30), .Depth(1024), .Latency(3)) dut_l3 (
    .clk_i(clk), .reset_ni(reset_n), .wb_data_i(wb_wdata), .wb_addr_i(wb_addr),
    .wb_sel_i(wb_sel), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .stall_inject_i(stall_inj), .wb_data_o(data3), .wb_ack_o(ack3),
    .wb_stall_o(stall3), .wb_err_o(err3)
  );

  // Reference model: each accepted request becomes a response due at a cycle.
  typedef struct {
    int          due;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } resp_t;

  resp_t       q1[$];
  resp_t       q3[$];
  logic [31:0] mem_m [1024];
  bit          known_m [1024];
  bit          stall_m;
  int          cyc_n;
  int          n_checks, n_fail;
  int          acks1, errs1, acks3, errs3;
  logic [31:0] last_d1, last_d3;
  logic [31:0] init_m [16];
  int          base_a, base_e;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic check_dut(input string nm, input bit has, input resp_t r,
                           input logic a, input logic e, input logic [31:0] d);
    bit ev;
    ev = has && wb_cyc && (r.due == cyc_n);
    check_eq({nm, "_ack"}, 64'(a), 64'(ev && !r.err));
    check_eq({nm, "_err"}, 64'(e), 64'(ev && r.err));
    if (!ev || r.chk) check_eq({nm, "_data"}, 64'(d), 64'(ev ? r.data : 32'h0));
  endtask

  task automatic model_edge();
    bit    acc;
    bit    inr;
    int    idx;
    resp_t r;
    if (!reset_n) begin
      q1.delete();
      q3.delete();
      stall_m = 1'b1;
    end else begin
      acc = wb_cyc && wb_stb && !stall_m;
      if (q1.size() > 0 && q1[0].due == cyc_n) void'(q1.pop_front());
      if (q3.size() > 0 && q3[0].due == cyc_n) void'(q3.pop_front());
      if (!wb_cyc) begin
        q1.delete();
        q3.delete();
      end else if (acc) begin
        idx    = int'(wb_addr[9:0]);
        inr    = wb_addr < 30'd1024;
        r.err  = !inr;
        r.chk  = 1'b1;
        r.data = 32'h0;
        if (inr && !wb_we) begin
          r.chk  = known_m[idx];
          r.data = mem_m[idx];
        end
        if (inr && wb_we) begin
          for (int k = 0; k < 4; k++)
            if (wb_sel[k]) mem_m[idx][8*k +: 8] = wb_wdata[8*k +: 8];
          if (wb_sel == 4'hF) known_m[idx] = 1'b1;
        end
        r.due = cyc_n + 1;
        q1.push_back(r);
        r.due = cyc_n + 3;
        q3.push_back(r);
      end
      stall_m = stall_inj;
    end
  endtask

  // One bus cycle: check outputs mid-cycle, then advance model at the edge.
  task automatic step();
    resp_t r1, r3;
    @(negedge clk);
    r1 = '{default: 0};
    r3 = '{default: 0};
    if (q1.size() > 0) r1 = q1[0];
    if (q3.size() > 0) r3 = q3[0];
    check_dut("l1", q1.size() > 0, r1, ack1, err1, data1);
    check_dut("l3", q3.size() > 0, r3, ack3, err3, data3);
    check_eq("l1_stall", 64'(stall1), 64'(stall_m));
    check_eq("l3_stall", 64'(stall3), 64'(stall_m));
    if (ack1) begin acks1++; last_d1 = data1; end
    if (err1) errs1++;
    if (ack3) begin acks3++; last_d3 = data3; end
    if (err3) errs3++;
    @(posedge clk);
    model_edge();
    cyc_n++;
    #1;
  endtask

  task automatic drive(input bit c, input bit s, input bit w, input logic [29:0] a,
                       input logic [3:0] sl, input logic [31:0] d, input bit inj);
    wb_cyc = c; wb_stb = s; wb_we = w; wb_addr = a; wb_sel = sl; wb_wdata = d;
    stall_inj = inj;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 30'd0, 4'h0, 32'h0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = '0; wb_sel = '0; wb_wdata = '0;
    stall_inj = 0;
    n_checks = 0; n_fail = 0; cyc_n = 0;
    acks1 = 0; errs1 = 0; acks3 = 0; errs3 = 0;
    last_d1 = '0; last_d3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 64'(stall1), 64'd1);
    check_eq("rst_ack",   64'(ack3),   64'd0);
    check_eq("rst_err",   64'(err3),   64'd0);
    check_eq("rst_data",  64'(data1),  64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    stall_m = 1'b1;

    idle(1);
    drive(1, 1, 1, 30'd5, 4'hF, 32'hDEADBEEF, 0);
    idle(1);
    drive(1, 1, 0, 30'd5, 4'h0, 32'h0, 0);
    idle(4);
    check_eq("rd5_l1", 64'(last_d1), 64'h0DEADBEEF);
    check_eq("rd5_l3", 64'(last_d3), 64'h0DEADBEEF);

    drive(1, 1, 1, 30'd2, 4'hF, 32'h11223344, 0);
    drive(1, 1, 1, 30'd2, 4'h5, 32'hAABBCCDD, 0);
    drive(1, 1, 0, 30'd2, 4'hF, 32'h0, 0);
    idle(4);
    check_eq("bytelane_l1", 64'(last_d1), 64'h11BB33DD);
    check_eq("bytelane_l3", 64'(last_d3), 64'h11BB33DD);

    for (int i = 0; i < 16; i++) begin
      init_m[i] = $urandom;
      drive(1, 1, 1, 30'(i), 4'hF, init_m[i], 0);
    end
    drive(1, 1, 1, 30'd1023, 4'hF, 32'hCAFE03FF, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 30'(i), 4'h0, 32'h0, 0);
    idle(4);
    check_eq("burst_last_l3", 64'(last_d3), 64'(init_m[3]));

    base_e = errs1;
    drive(1, 1, 0, 30'd1024, 4'hF, 32'h0, 0);
    drive(1, 1, 1, 30'h3FFFFFFF, 4'hF, 32'h0, 0);
    idle(4);
    check_eq("oor_errs_l1", 64'(errs1 - base_e), 64'd2);
    drive(1, 1, 0, 30'd1023, 4'h0, 32'h0, 0);
    idle(4);
    check_eq("oor_nowrite", 64'(last_d1), 64'hCAFE03FF);

    base_a = acks1;
    drive(1, 0, 0, 30'd7, 4'h0, 32'h0, 1);
    drive(1, 1, 0, 30'd7, 4'h0, 32'h0, 1);
    drive(1, 1, 0, 30'd7, 4'h0, 32'h0, 0);
    drive(1, 1, 0, 30'd7, 4'h0, 32'h0, 0);
    idle(4);
    check_eq("stall_once", 64'(acks1 - base_a), 64'd1);

    base_a = acks3 + errs3;
    drive(1, 1, 0, 30'd0, 4'h0, 32'h0, 0);
    drive(1, 1, 0, 30'd1, 4'h0, 32'h0, 0);
    drive(0, 0, 0, 30'd0, 4'h0, 32'h0, 0);
    idle(5);
    check_eq("abort_cyc_l3", 64'(acks3 + errs3 - base_a), 64'd0);

    base_a = acks3 + errs3;
    drive(1, 1, 0, 30'd0, 4'h0, 32'h0, 0);
    drive(1, 1, 0, 30'd1, 4'h0, 32'h0, 0);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    check_eq("mid_rst_stall", 64'(stall3), 64'd1);
    idle(5);
    check_eq("abort_rst_l3", 64'(acks3 + errs3 - base_a), 64'd0);

    for (int n = 0; n < 600; n++) begin
      logic [29:0] a;
      case ($urandom_range(0, 9))
        0:       a = 30'd1024 + 30'($urandom_range(0, 1000));
        1:       a = 30'h3FFFFFFF;
        default: a = 30'($urandom_range(0, 15));
      endcase
      reset_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 19) != 0, 1'($urandom), 1'($urandom), a,
            4'($urandom), $urandom, $urandom_range(0, 7) == 0);
      reset_n = 1'b1;
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
